// File: rtl/imm_dec_ctrl.sv
// Decode front end: classifies the opcode, generates the immediate and buffers
// {pc, inst, imm, imm_sel} in a 2-entry skid FIFO. Optional macro: IMM_ILLEGAL_CHK_EN.
module imm_dec_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   wr_ptr_q, wr_ptr_d;
  logic   rd_ptr_q, rd_ptr_d;
  logic   in_ready_q, out_valid_q;
  logic   push_c, pop_c;

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [XLEN-1:0]  imm_q  [DEPTH];
  logic [SEL_W-1:0] sel_q  [DEPTH];

  logic [XLEN-1:0]  imm_c;
  logic [SEL_W-1:0] sel_c;

  // Opcode classification and sign-extended immediate for the incoming word
  always_comb begin
    sel_c = 3'b000;
    imm_c = '0;
    unique case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
        sel_c = 3'b001;
        imm_c = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
      end
      7'b0110111, 7'b0010111: begin
        sel_c = 3'b010;
        imm_c = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
      end
      7'b1100011: begin
        sel_c = 3'b011;
        imm_c = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        sel_c = 3'b100;
        imm_c = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b0100011: begin
        sel_c = 3'b101;
        imm_c = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      default: begin
        sel_c = 3'b000;
        imm_c = '0;
      end
    endcase
  end

  assign push_c = in_valid & in_ready_q & ~flush;
  assign pop_c  = out_valid_q & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Occupancy FSM; flush overrides everything and realigns both pointers
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      ST_EMPTY: if (push_c) state_d = ST_ONE;
      ST_ONE: begin
        if (push_c && !pop_c)      state_d = ST_FULL;
        else if (pop_c && !push_c) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop_c) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (push_c) wr_ptr_d = ~wr_ptr_q;
    if (pop_c)  rd_ptr_d = ~rd_ptr_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        imm_q[i]  <= '0;
        sel_q[i]  <= '0;
      end
    end else if (push_c) begin
      pc_q[wr_ptr_q]   <= in_pc;
      inst_q[wr_ptr_q] <= in_inst;
      imm_q[wr_ptr_q]  <= imm_c;
      sel_q[wr_ptr_q]  <= sel_c;
    end
  end

`ifdef IMM_ILLEGAL_CHK_EN
  logic ill_q [DEPTH];
  logic ill_c;

  // Only R-type opcodes are legal among those without an immediate
  assign ill_c = (sel_c == 3'b000) &&
                 (in_inst[6:0] != 7'b0110011) && (in_inst[6:0] != 7'b0111011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ill_q[i] <= 1'b0;
    end else if (push_c) begin
      ill_q[wr_ptr_q] <= ill_c;
    end
  end

  assign out_illegal = ill_q[rd_ptr_q];
`else
  assign out_illegal = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_inst    = inst_q[rd_ptr_q];
  assign out_imm     = imm_q[rd_ptr_q];
  assign out_imm_sel = sel_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_dec_ctrl.sv
// Scoreboard bench for imm_dec_ctrl: stimulus queues expected entries, a negedge
// monitor checks the FIFO head against the queue front whenever out_valid is high.
module tb_imm_dec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] out_imm;
  logic [2:0]  out_imm_sel;
  logic        out_illegal;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef IMM_ILLEGAL_CHK_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  imm_dec_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_imm     (out_imm),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare head with scoreboard front, pop on handshake
  always @(negedge clk) begin
    if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc 0x%0h inst 0x%0h expected no entry", out_pc, out_inst);
      end else begin
        chk("out_pc",      out_pc,              sb[0].pc);
        chk("out_inst",    64'(out_inst),       64'(sb[0].inst));
        chk("out_imm",     out_imm,             sb[0].imm);
        chk("out_imm_sel", 64'(out_imm_sel),    64'(sb[0].sel));
        chk("out_illegal", 64'(out_illegal),    64'(sb[0].ill));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] pc, input logic [31:0] inst,
                      input logic [63:0] imm, input logic [2:0] sel, input logic ill);
    int n = 0;
    exp_t e;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for pc 0x%0h", pc);
    end else begin
      e.pc = pc; e.inst = inst; e.imm = imm; e.sel = sel; e.ill = ill;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_in_ready",  64'(in_ready),    64'd1);
    chk("rst_out_pc",    out_pc,           64'd0);
    chk("rst_out_imm",   out_imm,          64'd0);
    chk("rst_sel",       64'(out_imm_sel), 64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode patterns with one-cycle latency on the first
    send(64'h8000_0000, 32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b0);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    send(64'h8000_0004, 32'h1234_50B7, 64'h0000_0000_1234_5000, 3'b010, 1'b0);
    send(64'h8000_0008, 32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'b011, 1'b0);
    send(64'h8000_000C, 32'h0080_006F, 64'd8,                   3'b100, 1'b0);
    send(64'h8000_0010, 32'h0011_2223, 64'd4,                   3'b101, 1'b0);
    send(64'h8000_0014, 32'h0020_81B3, 64'd0,                   3'b000, 1'b0);
    send(64'h8000_0018, 32'h0000_007F, 64'd0,                   3'b000, ILL_EXP);
    send(64'h8000_001C, 32'h8000_0013, 64'hFFFF_FFFF_FFFF_F800, 3'b001, 1'b0);
    drain();

    // Back-pressure: third push blocked until EXU drains
    @(posedge clk); #1 out_ready = 1'b0;
    send(64'h100, 32'h0010_0093, 64'd1, 3'b001, 1'b0);
    send(64'h104, 32'h0020_0093, 64'd2, 3'b001, 1'b0);
    in_valid = 1'b1; in_pc = 64'h108; in_inst = 32'h0030_0093;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(64'h108, 32'h0030_0093, 64'd3, 3'b001, 1'b0);
    drain();

    // Flush while full drops stored entries and the same-cycle input
    @(posedge clk); #1 out_ready = 1'b0;
    send(64'h200, 32'h0040_0093, 64'd4, 3'b001, 1'b0);
    send(64'h204, 32'h0050_0093, 64'd5, 3'b001, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'hDEAD; in_inst = 32'h0060_0093;
    sb.delete();
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    send(64'h300, 32'h0070_0093, 64'd7, 3'b001, 1'b0);
    drain();

    // Async reset mid-stream empties the FIFO immediately
    @(posedge clk); #1 out_ready = 1'b0;
    send(64'h400, 32'h1234_50B7, 64'h0000_0000_1234_5000, 3'b010, 1'b0);
    send(64'h404, 32'h0080_006F, 64'd8, 3'b100, 1'b0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid),   64'd0);
    chk("arst_in_ready",  64'(in_ready),    64'd1);
    chk("arst_out_pc",    out_pc,           64'd0);
    chk("arst_out_inst",  64'(out_inst),    64'd0);
    chk("arst_sel",       64'(out_imm_sel), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(64'h500, 32'h0011_2223, 64'd4, 3'b101, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
